// File: rtl/tfhe_dma_pkg.sv
// Shared definitions for the TFHE host-memory DMA engines (read burst
// reader and write-side packer).
//   AXI_BURST_INCR  - ARBURST/AWBURST encoding for incrementing bursts
//   AXI_RESP_OKAY   - RRESP/BRESP encoding for a successful beat
//   rd_state_e      - read engine sequencing states
//   bytes_per_burst - byte span of one full burst, used for address stepping
package tfhe_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_e;

  function automatic int unsigned bytes_per_burst(input int unsigned burst_len,
                                                  input int unsigned data_width);
    return burst_len * (data_width / 8);
  endfunction

endpackage

// File: rtl/tfhe_sync_fifo.sv
// Single-clock FIFO with flop-based storage. Read data is taken straight from
// the storage registers at the read pointer, so a word written in cycle n is
// visible (empty_o low) in cycle n+1 with no combinational path from the
// write side.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   wr_en_i, wr_data_i      push (ignored when full)
//   rd_en_i                 pop  (ignored when empty)
//   rd_data_o               head-of-queue word
//   full_o, empty_o         occupancy flags
//   count_o                 number of stored words, 0..DEPTH
module tfhe_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW:0]           count_q;
  logic                  wr_do, rd_do;

  assign full_o    = (count_q == CNT_MAX);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_do     = wr_en_i & ~full_o;
  assign rd_do     = rd_en_i & ~empty_o;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (wr_do) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_do) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_do) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({wr_do, rd_do})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tfhe_axi_burst_reader.sv
// AXI4 read-burst engine: fetches num_bursts full INCR bursts starting at an
// aligned base address and streams the beats out on a valid/ready port.
// ARs are only issued when the beat FIFO has room for a whole burst, so
// RREADY stays high for the entire RUN phase.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_start, i_base_addr,
//   i_num_bursts                    transfer request (sampled in IDLE only)
//   o_busy, o_done, o_error         status (o_error sticky until next start)
//   M_AXI_AR*                       read address channel
//   M_AXI_R*                        read data channel
//   o_data, o_valid, o_last,
//   i_ready                         downstream beat stream
module tfhe_axi_burst_reader
  import tfhe_dma_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 256,
  parameter int unsigned C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH         = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [15:0]                   i_num_bursts,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_data,
  output logic                          o_valid,
  output logic                          o_last,
  input  logic                          i_ready
);

  localparam int unsigned AXW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BL     = C_M_AXI_BURST_LEN;
  localparam int unsigned BPB    = bytes_per_burst(BL, C_M_AXI_DATA_WIDTH);
  localparam int unsigned LOG_BL = $clog2(BL);
  localparam int unsigned BCW    = (LOG_BL == 0) ? 1 : LOG_BL;
  localparam int unsigned TW     = 16 + LOG_BL;
  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [AXW-1:0] ADDR_INC   = AXW'(BPB);
  localparam logic [AXW-1:0] ADDR_MASK  = ~(AXW'(BPB) - AXW'(1));
  localparam logic [CW-1:0]  CRED_BURST = CW'(BL);
  localparam logic [CW-1:0]  CRED_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CRED_ONE   = CW'(1);
  localparam logic [BCW-1:0] BEAT_LAST  = BCW'(BL - 1);
  localparam logic [BCW-1:0] BEAT_ONE   = BCW'(1);

  rd_state_e           state_q;
  logic [AXW-1:0]      araddr_q;
  logic                arvalid_q, rready_q, busy_q, done_q, error_q;
  logic [15:0]         nbursts_q, issued_q;
  logic [TW-1:0]       total_q, recv_q, deliv_q;
  logic [CW-1:0]       credit_q;
  logic [BCW-1:0]      beat_q;

  logic                ar_hs, r_hs, pop, final_pop, ar_want, beat_err;
  logic [CW-1:0]       credit_d;
  logic [15:0]         issued_d;
  logic [TW-1:0]       recv_d, deliv_d;
  logic                fifo_full, fifo_empty, fifo_valid;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                unused_fifo_status;

  assign ar_hs      = arvalid_q & M_AXI_ARREADY;
  assign r_hs       = M_AXI_RVALID & rready_q;
  assign fifo_valid = ~fifo_empty;
  assign pop        = fifo_valid & i_ready;
  assign final_pop  = pop & (deliv_q == total_q - TW'(1));

  // AR handshake and downstream pop in the same cycle both apply.
  assign credit_d = credit_q - (ar_hs ? CRED_BURST : '0) + (pop ? CRED_ONE : '0);
  assign issued_d = issued_q + 16'(ar_hs);
  assign recv_d   = recv_q + TW'(r_hs);
  assign deliv_d  = deliv_q + TW'(pop);
  assign ar_want  = (issued_d < nbursts_q) && (credit_d >= CRED_BURST);

  // RLAST must arrive exactly on the final beat of each burst.
  assign beat_err = r_hs & (M_AXI_RLAST ? (beat_q != BEAT_LAST) : (beat_q == BEAT_LAST));

  assign unused_fifo_status = ^{fifo_full, fifo_count};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      nbursts_q <= '0;
      issued_q  <= '0;
      total_q   <= '0;
      recv_q    <= '0;
      deliv_q   <= '0;
      credit_q  <= CRED_FULL;
      beat_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            araddr_q  <= i_base_addr & ADDR_MASK;
            nbursts_q <= i_num_bursts;
            total_q   <= TW'(i_num_bursts) << LOG_BL;
            issued_q  <= '0;
            recv_q    <= '0;
            deliv_q   <= '0;
            credit_q  <= CRED_FULL;
            beat_q    <= '0;
            error_q   <= 1'b0;
            if (i_num_bursts == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
              rready_q  <= 1'b1;
              // FIFO is empty, so the first burst always has credit.
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          credit_q <= credit_d;
          issued_q <= issued_d;
          recv_q   <= recv_d;
          deliv_q  <= deliv_d;
          if (ar_hs) araddr_q <= araddr_q + ADDR_INC;
          // A pending AR is held until accepted.
          if (!arvalid_q || M_AXI_ARREADY) arvalid_q <= ar_want;
          if (r_hs) beat_q <= M_AXI_RLAST ? '0 : beat_q + BEAT_ONE;
          if (beat_err || (r_hs && (M_AXI_RRESP != AXI_RESP_OKAY))) error_q <= 1'b1;
          if (r_hs && (recv_d == total_q)) begin
            state_q  <= ST_FLUSH;
            rready_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          credit_q <= credit_d;
          deliv_q  <= deliv_d;
          if (final_pop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  tfhe_sync_fifo #(
    .DATA_WIDTH (C_M_AXI_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .wr_en_i   (r_hs),
    .wr_data_i (M_AXI_RDATA),
    .rd_en_i   (pop),
    .rd_data_o (o_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = 8'(BL - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign o_valid       = fifo_valid;
  assign o_last        = fifo_valid & (deliv_q == total_q - TW'(1));
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_tfhe_axi_burst_reader.sv
module tb_tfhe_axi_burst_reader;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int BL = 16;
  localparam int FD = 32;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [15:0]   i_num_bursts = '0;
  logic          o_busy, o_done, o_error;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARVALID;
  logic          ARREADY = 1'b0;
  logic [DW-1:0] RDATA = '0;
  logic [1:0]    RRESP = 2'b00;
  logic          RLAST = 1'b0;
  logic          RVALID = 1'b0;
  logic          RREADY;
  logic [DW-1:0] o_data;
  logic          o_valid, o_last;
  logic          i_ready = 1'b1;

  always #5 clk = ~clk;

  tfhe_axi_burst_reader #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_M_AXI_BURST_LEN  (BL),
    .FIFO_DEPTH         (FD)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_base_addr   (i_base_addr),
    .i_num_bursts  (i_num_bursts),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .M_AXI_ARADDR  (ARADDR),
    .M_AXI_ARLEN   (ARLEN),
    .M_AXI_ARSIZE  (ARSIZE),
    .M_AXI_ARBURST (ARBURST),
    .M_AXI_ARVALID (ARVALID),
    .M_AXI_ARREADY (ARREADY),
    .M_AXI_RDATA   (RDATA),
    .M_AXI_RRESP   (RRESP),
    .M_AXI_RLAST   (RLAST),
    .M_AXI_RVALID  (RVALID),
    .M_AXI_RREADY  (RREADY),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_last        (o_last),
    .i_ready       (i_ready)
  );

  int errors = 0;
  int checks = 0;

  // Monitor: samples 1 ns before each rising edge, i.e. exactly the values
  // the DUT will act on at that edge.
  logic          mon_clr = 1'b0;
  logic          mon_rst_s = 1'b1;
  logic          ar_took = 1'b0;
  logic          r_took = 1'b0;
  logic [AW-1:0] ar_took_addr = '0;
  logic [31:0]   exp_base = '0;
  logic [AW-1:0] ar_log[$];
  int cyc = 0;
  int ar_cnt = 0, r_cnt = 0, pop_cnt = 0, mism = 0, last_cnt = 0, last_idx = -1;
  int done_cnt = 0, done_busy = 0, ovf = 0, occ = 0, ar_hold_bad = 0, ar_wait_cyc = 0;
  int first_r_cyc = -1, first_v_cyc = -1, last_pop_cyc = -1, done_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_araddr = '0;

  always @(negedge clk) begin
    logic [31:0] tag;
    #4;
    cyc++;
    mon_rst_s    = i_reset;
    ar_took      = !i_reset && ARVALID && ARREADY;
    ar_took_addr = ARADDR;
    r_took       = !i_reset && RVALID && RREADY;
    if (i_reset || mon_clr) begin
      ar_cnt = 0; r_cnt = 0; pop_cnt = 0; mism = 0; last_cnt = 0; last_idx = -1;
      done_cnt = 0; done_busy = 0; ovf = 0; occ = 0; ar_hold_bad = 0; ar_wait_cyc = 0;
      first_r_cyc = -1; first_v_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
      prev_stall = 1'b0;
      ar_log.delete();
    end else begin
      if (prev_stall && (!ARVALID || ARADDR != prev_araddr)) ar_hold_bad++;
      prev_stall  = ARVALID && !ARREADY;
      prev_araddr = ARADDR;
      if (ARVALID && !ARREADY) ar_wait_cyc++;
      if (ar_took) begin ar_cnt++; ar_log.push_back(ARADDR); end
      if (r_took) begin
        if (occ >= FD) ovf++;
        r_cnt++;
        if (first_r_cyc < 0) first_r_cyc = cyc;
      end
      if (o_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (o_valid && i_ready) begin
        tag = exp_base + 32'(pop_cnt * 32);
        if (o_data !== {8{tag}}) mism++;
        if (o_last) begin last_cnt++; last_idx = pop_cnt; last_pop_cyc = cyc; end
        pop_cnt++;
      end
      occ = occ + (r_took ? 1 : 0) - ((o_valid && i_ready) ? 1 : 0);
      if (o_done) begin done_cnt++; done_cyc = cyc; done_busy = o_busy ? 1 : 0; end
    end
  end

  // AXI slave: data word for beat b of a burst at address a is {8{a+32*b}}.
  logic [AW-1:0] rq[$];
  logic [AW-1:0] r_addr = '0;
  logic [AW-1:0] err_addr = '1;
  int r_beat = 0, ar_wait = 0, ar_delay = 0, err_beat = -1;

  always @(negedge clk) begin
    logic [31:0] tag;
    if (mon_rst_s) begin
      rq.delete();
      RVALID = 1'b0; RLAST = 1'b0; ARREADY = 1'b0; ar_wait = 0;
    end else begin
      if (ar_took) rq.push_back(ar_took_addr);
      if (ARVALID) begin
        if (ar_wait >= ar_delay) begin ARREADY = 1'b1; ar_wait = 0; end
        else begin ARREADY = 1'b0; ar_wait++; end
      end else ARREADY = 1'b0;
      if (RVALID && r_took) begin
        if (r_beat == BL - 1) RVALID = 1'b0;
        else r_beat++;
      end
      if (!RVALID && rq.size() > 0) begin
        r_addr = rq.pop_front(); r_beat = 0; RVALID = 1'b1;
      end
      tag   = r_addr[31:0] + 32'(r_beat * 32);
      RDATA = {8{tag}};
      RLAST = RVALID && (r_beat == BL - 1);
      RRESP = (RVALID && r_addr == err_addr && r_beat == err_beat) ? 2'b10 : 2'b00;
    end
  end

  task automatic mon_clear();
    @(negedge clk) mon_clr = 1'b1;
    @(negedge clk) mon_clr = 1'b0;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [15:0] n);
    @(negedge clk);
    i_start = 1'b1; i_base_addr = base; i_num_bursts = n;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL %s_timeout: no o_done within %0d cycles", name, budget); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b want 0", ARVALID); end
    checks++; if (ARADDR !== '0) begin errors++; $display("FAIL rst_araddr: got %0h want 0", ARADDR); end
    checks++; if (RREADY !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b want 0", RREADY); end
    checks++; if (o_valid !== 1'b0 || o_last !== 1'b0) begin errors++; $display("FAIL rst_stream: valid=%b last=%b want 0 0", o_valid, o_last); end
    checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0) begin errors++; $display("FAIL rst_status: busy=%b done=%b err=%b want 000", o_busy, o_done, o_error); end
    @(negedge clk) i_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ARLEN !== 8'd15 || ARSIZE !== 3'd5 || ARBURST !== 2'b01) begin errors++; $display("FAIL ar_const: len=%0d size=%0d burst=%0d want 15 5 1", ARLEN, ARSIZE, ARBURST); end
    checks++; if (o_busy !== 1'b0 || ARVALID !== 1'b0) begin errors++; $display("FAIL idle_after_rst: busy=%b arvalid=%b want 0 0", o_busy, ARVALID); end
  endtask

  task automatic test_basic();
    mon_clear(); i_ready = 1'b1; exp_base = 32'h1000_0000;
    start(64'h1000_0040, 16'd3);
    checks++; if (o_busy !== 1'b1 || ARVALID !== 1'b1) begin errors++; $display("FAIL basic_cycle1: busy=%b arvalid=%b want 1 1", o_busy, ARVALID); end
    checks++; if (ARADDR !== 64'h1000_0000) begin errors++; $display("FAIL basic_align: got %0h want 10000000", ARADDR); end
    wait_done("basic", 400);
    checks++; if (ar_cnt !== 3) begin errors++; $display("FAIL basic_ar_cnt: got %0d want 3", ar_cnt); end
    checks++; if (ar_log[0] !== 64'h1000_0000 || ar_log[1] !== 64'h1000_0200 || ar_log[2] !== 64'h1000_0400) begin
      errors++; $display("FAIL basic_ar_addr: got %0h %0h %0h want 10000000 10000200 10000400", ar_log[0], ar_log[1], ar_log[2]); end
    checks++; if (pop_cnt !== 48 || mism !== 0) begin errors++; $display("FAIL basic_data: pops=%0d bad=%0d want 48 0", pop_cnt, mism); end
    checks++; if (last_cnt !== 1 || last_idx !== 47) begin errors++; $display("FAIL basic_last: cnt=%0d idx=%0d want 1 47", last_cnt, last_idx); end
    checks++; if (first_v_cyc - first_r_cyc !== 1) begin errors++; $display("FAIL basic_r_to_valid: got %0d want 1", first_v_cyc - first_r_cyc); end
    checks++; if (done_cyc - last_pop_cyc !== 1 || done_busy !== 0) begin errors++; $display("FAIL basic_done_timing: lat=%0d busy=%0d want 1 0", done_cyc - last_pop_cyc, done_busy); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== 1 || o_error !== 1'b0) begin errors++; $display("FAIL basic_done_once: done=%0d err=%b want 1 0", done_cnt, o_error); end
  endtask

  task automatic test_backpressure();
    mon_clear(); i_ready = 1'b0; exp_base = 32'h0;
    start(64'h0, 16'd4);
    repeat (100) @(negedge clk);
    checks++; if (ar_cnt !== 2 || ARVALID !== 1'b0) begin errors++; $display("FAIL bp_two_ar: ar=%0d arvalid=%b want 2 0", ar_cnt, ARVALID); end
    checks++; if (r_cnt !== 32 || pop_cnt !== 0 || o_valid !== 1'b1) begin errors++; $display("FAIL bp_buffered: r=%0d pops=%0d valid=%b want 32 0 1", r_cnt, pop_cnt, o_valid); end
    i_ready = 1'b1;
    repeat (15) @(negedge clk);
    i_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (ar_cnt !== 2 || pop_cnt !== 15) begin errors++; $display("FAIL bp_15_pops: ar=%0d pops=%0d want 2 15", ar_cnt, pop_cnt); end
    i_ready = 1'b1;
    @(negedge clk) i_ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (ar_cnt !== 3) begin errors++; $display("FAIL bp_third_ar: got %0d want 3", ar_cnt); end
    i_ready = 1'b1;
    wait_done("bp", 400);
    checks++; if (pop_cnt !== 64 || mism !== 0 || last_idx !== 63) begin errors++; $display("FAIL bp_data: pops=%0d bad=%0d last=%0d want 64 0 63", pop_cnt, mism, last_idx); end
    checks++; if (ovf !== 0) begin errors++; $display("FAIL bp_overflow: got %0d want 0", ovf); end
  endtask

  task automatic test_ar_delay();
    mon_clear(); ar_delay = 5; exp_base = 32'h6000;
    start(64'h6000, 16'd2);
    wait_done("ardly", 400);
    ar_delay = 0;
    checks++; if (ar_cnt !== 2 || ar_log[0] !== 64'h6000 || ar_log[1] !== 64'h6200) begin errors++; $display("FAIL ardly_ar: cnt=%0d a0=%0h a1=%0h want 2 6000 6200", ar_cnt, ar_log[0], ar_log[1]); end
    checks++; if (ar_hold_bad !== 0 || ar_wait_cyc !== 10) begin errors++; $display("FAIL ardly_hold: bad=%0d wait=%0d want 0 10", ar_hold_bad, ar_wait_cyc); end
    checks++; if (pop_cnt !== 32 || mism !== 0) begin errors++; $display("FAIL ardly_data: pops=%0d bad=%0d want 32 0", pop_cnt, mism); end
  endtask

  task automatic test_rresp_err();
    mon_clear(); exp_base = 32'h7000; err_addr = 64'h7000; err_beat = 7;
    start(64'h7000, 16'd1);
    wait_done("err", 300);
    err_beat = -1;
    checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", o_error); end
    checks++; if (pop_cnt !== 16 || mism !== 0 || last_idx !== 15) begin errors++; $display("FAIL err_data: pops=%0d bad=%0d last=%0d want 16 0 15", pop_cnt, mism, last_idx); end
    repeat (4) @(negedge clk);
    checks++; if (o_error !== 1'b1 || done_cnt !== 1) begin errors++; $display("FAIL err_sticky: err=%b done=%0d want 1 1", o_error, done_cnt); end
  endtask

  task automatic test_zero_bursts();
    mon_clear();
    start(64'h8000, 16'd0);
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b want 1 0", o_done, o_busy); end
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL zero_err_clear: got %b want 0", o_error); end
    @(negedge clk);
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL zero_pulse: got %b want 0", o_done); end
    repeat (5) @(negedge clk);
    checks++; if (ar_cnt !== 0 || ARVALID !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL zero_no_ar: ar=%0d arvalid=%b done=%0d want 0 0 1", ar_cnt, ARVALID, done_cnt); end
  endtask

  task automatic test_start_ignored();
    mon_clear(); exp_base = 32'h2000;
    start(64'h2000, 16'd2);
    repeat (3) @(negedge clk);
    i_start = 1'b1; i_base_addr = 64'h9000; i_num_bursts = 16'd5;
    @(negedge clk) i_start = 1'b0;
    wait_done("ign", 400);
    repeat (5) @(negedge clk);
    checks++; if (ar_cnt !== 2 || ar_log[1] !== 64'h2200) begin errors++; $display("FAIL ign_ar: cnt=%0d a1=%0h want 2 2200", ar_cnt, ar_log[1]); end
    checks++; if (pop_cnt !== 32 || mism !== 0 || done_cnt !== 1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL ign_data: pops=%0d bad=%0d done=%0d busy=%b want 32 0 1 0", pop_cnt, mism, done_cnt, o_busy); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mon_clear(); exp_base = 32'h3000;
    start(64'h3000, 16'd3);
    while (r_cnt < 20 && n < 200) begin @(negedge clk); n++; end
    checks++; if (r_cnt < 20) begin errors++; $display("FAIL rmid_reach: r=%0d want >=20", r_cnt); end
    i_reset = 1'b1;
    @(negedge clk);
    checks++; if (ARVALID !== 1'b0 || ARADDR !== '0 || RREADY !== 1'b0) begin errors++; $display("FAIL rmid_axi: arvalid=%b araddr=%0h rready=%b want 0 0 0", ARVALID, ARADDR, RREADY); end
    checks++; if (o_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_error !== 1'b0) begin
      errors++; $display("FAIL rmid_status: valid=%b last=%b busy=%b done=%b err=%b want 00000", o_valid, o_last, o_busy, o_done, o_error); end
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    mon_clear(); exp_base = 32'h4000;
    start(64'h4000, 16'd2);
    wait_done("rmid", 400);
    checks++; if (pop_cnt !== 32 || mism !== 0 || last_idx !== 31 || ar_log[0] !== 64'h4000) begin
      errors++; $display("FAIL rmid_restart: pops=%0d bad=%0d last=%0d a0=%0h want 32 0 31 4000", pop_cnt, mism, last_idx, ar_log[0]); end
    checks++; if (o_error !== 1'b0 || ovf !== 0) begin errors++; $display("FAIL rmid_clean: err=%b ovf=%0d want 0 0", o_error, ovf); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ar_delay();
    test_rresp_err();
    test_zero_bursts();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
